s_to_u_pipe: RTL



---
 rtl/tc_sm_pkg.sv | 19 +
 rtl/sm_lane.sv | 58 +++++
 rtl/s_to_u_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/tc_sm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_sm_pkg
// Brief    : Shared mode encoding and default sizes for the two's-complement /
//            sign-magnitude conversion pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package tc_sm_pkg;

    typedef enum logic {
        SM_TO_MAG  = 1'b0,
        SM_TO_TWOS = 1'b1
    } sm_mode_t;

    localparam int c_default_width = 14;
    localparam int c_default_lanes = 4;

endpackage
`default_nettype wire

// File: rtl/sm_lane.sv
`default_nettype none
// ============================================================================
// Module   : sm_lane
// Brief    : Combinational single-lane converter between two's complement and
//            sign-magnitude, with most-negative saturation.
// Revision : 1.0 - initial release
// ============================================================================
module sm_lane
    import tc_sm_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_sign,
    input  sm_mode_t         i_mode,
    output logic [WIDTH-1:0] o_result,
    output logic             o_sign,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam logic [WIDTH-2:0] c_one_m = (WIDTH-1)'(1);

    logic             w_is_min;
    logic [WIDTH-2:0] w_neg_mag;
    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_ext_neg;

    assign w_is_min  = (i_value == {1'b1, {(WIDTH-1){1'b0}}});
    // Only the low bits of -x are needed; the MSB of |x| is always 0 once the
    // most-negative value is handled separately.
    assign w_neg_mag = ~i_value[WIDTH-2:0] + c_one_m;
    assign w_ext     = {1'b0, i_value[WIDTH-2:0]};
    assign w_ext_neg = ~w_ext + c_one;

    always_comb begin
        o_result = '0;
        o_sign   = 1'b0;
        o_ovf    = 1'b0;
        if (i_mode == SM_TO_MAG) begin
            o_sign = i_value[WIDTH-1];
            if (w_is_min) begin
                o_result = {1'b0, {(WIDTH-1){1'b1}}};
                o_ovf    = 1'b1;
            end else if (i_value[WIDTH-1]) begin
                o_result = {1'b0, w_neg_mag};
            end else begin
                o_result = w_ext;
            end
        end else begin
            // Negative zero collapses to +0.
            o_sign   = i_sign & (|i_value[WIDTH-2:0]);
            o_result = i_sign ? w_ext_neg : w_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/s_to_u_pipe.sv
`default_nettype none
// ============================================================================
// Module   : s_to_u_pipe
// Brief    : Two-stage elastic multi-lane converter between two's complement
//            and sign-magnitude with per-lane saturation flags.
// Revision : 1.0 - initial release
// ============================================================================
module s_to_u_pipe
    import tc_sm_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int LANES = c_default_lanes
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mode,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_sign,
    output logic [LANES-1:0]       out_ovf
);

    logic                   r_va;
    sm_mode_t               r_mode_a;
    logic [LANES*WIDTH-1:0] r_data_a;
    logic [LANES-1:0]       r_sign_a;

    logic                   r_vb;
    sm_mode_t               r_mode_b;
    logic [LANES*WIDTH-1:0] r_data_b;
    logic [LANES-1:0]       r_sign_b;
    logic [LANES-1:0]       r_ovf_b;

    logic                   w_ready_a;
    logic                   w_ready_b;
    logic [LANES*WIDTH-1:0] w_lane_data;
    logic [LANES-1:0]       w_lane_sign;
    logic [LANES-1:0]       w_lane_ovf;

    // out_ready ripples straight through to in_ready so a full pipe can
    // accept and emit in the same cycle.
    assign w_ready_b = ~r_vb | out_ready;
    assign w_ready_a = ~r_va | w_ready_b;
    assign in_ready  = nRST & w_ready_a;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sm_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .i_value  (r_data_a[i*WIDTH +: WIDTH]),
                .i_sign   (r_sign_a[i]),
                .i_mode   (r_mode_a),
                .o_result (w_lane_data[i*WIDTH +: WIDTH]),
                .o_sign   (w_lane_sign[i]),
                .o_ovf    (w_lane_ovf[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_va     <= 1'b0;
            r_mode_a <= SM_TO_MAG;
            r_data_a <= '0;
            r_sign_a <= '0;
            r_vb     <= 1'b0;
            r_mode_b <= SM_TO_MAG;
            r_data_b <= '0;
            r_sign_b <= '0;
            r_ovf_b  <= '0;
        end else begin
            if (w_ready_a) begin
                r_va <= in_valid;
                if (in_valid) begin
                    r_mode_a <= sm_mode_t'(in_mode);
                    r_data_a <= in_data;
                    r_sign_a <= in_sign;
                end
            end
            if (w_ready_b) begin
                r_vb <= r_va;
                if (r_va) begin
                    r_mode_b <= r_mode_a;
                    r_data_b <= w_lane_data;
                    r_sign_b <= w_lane_sign;
                    r_ovf_b  <= w_lane_ovf;
                end
            end
        end
    end

    assign out_valid = r_vb;
    assign out_mode  = r_mode_b;
    assign out_data  = r_data_b;
    assign out_sign  = r_sign_b;
    assign out_ovf   = r_ovf_b;

endmodule
`default_nettype wire
